// File: rtl/remote_comm_pkg.sv
// Shared definitions for the remote-control link: response and command
// constants used by benches, UART frame length and the transmit FSM state type.
package remote_comm_pkg;

  localparam logic [7:0]  POS_ACK       = 8'hA5;   // robot positive acknowledge
  localparam logic [15:0] CMD_CALIBRATE = 16'h2000;
  localparam logic [15:0] CMD_MOVE      = 16'h47F3;

  // start + 8 data + stop
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/remote_comm_uart.sv
// 8N1 UART: one transmitter and one receiver running independently.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   RX           serial input (idles high)
//   TX           serial output (idles high)
//   trmt         one-cycle request to send tx_data (honoured only when idle)
//   tx_data      byte to send
//   tx_done      one-cycle pulse on the cycle after the stop bit ends
//   rx_rdy       high while rx_data holds a freshly received byte
//   rx_data      last received byte
//   clr_rx_rdy   clears rx_rdy
module remote_comm_uart
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  output logic       TX,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       rx_rdy,
  output logic [7:0] rx_data,
  input  logic       clr_rx_rdy
);

  localparam int unsigned CW = $clog2(BAUD_DIV + 1);

  // ---------------- transmitter ----------------
  logic          tx_busy;
  logic [CW-1:0] tx_baud;
  logic [3:0]    tx_bits;
  logic [8:0]    tx_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy  <= 1'b0;
      tx_baud  <= '0;
      tx_bits  <= '0;
      tx_shift <= '1;
      TX       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (trmt) begin
          tx_busy  <= 1'b1;
          tx_baud  <= '0;
          tx_bits  <= '0;
          tx_shift <= {1'b1, tx_data};   // stop bit rides in behind the data
          TX       <= 1'b0;              // start bit
        end
      end else if (tx_baud == CW'(BAUD_DIV - 1)) begin
        tx_baud <= '0;
        if (tx_bits == 4'(FRAME_BITS - 1)) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
          TX      <= 1'b1;
        end else begin
          tx_bits  <= tx_bits + 4'd1;
          TX       <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
        end
      end else begin
        tx_baud <= tx_baud + 1'b1;
      end
    end
  end

  // ---------------- receiver ----------------
  logic          rx_s1, rx_s2, rx_prev;
  logic          rx_busy;
  logic [CW-1:0] rx_baud;
  logic [3:0]    rx_bits;
  logic [8:0]    rx_shift;
  logic          start_edge;

  assign start_edge = !rx_busy && rx_prev && !rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_busy  <= 1'b0;
      rx_baud  <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (start_edge || clr_rx_rdy)
        rx_rdy <= 1'b0;
      if (start_edge) begin
        rx_busy <= 1'b1;
        rx_baud <= CW'(BAUD_DIV / 2 - 1);   // first sample lands mid start bit
        rx_bits <= '0;
      end else if (rx_busy) begin
        if (rx_baud == '0) begin
          rx_baud  <= CW'(BAUD_DIV - 1);
          rx_shift <= {rx_s2, rx_shift[8:1]};
          // 10th sample is the stop bit: start sits in [0], data in [8:1]
          if (rx_bits == 4'(FRAME_BITS - 1)) begin
            rx_busy <= 1'b0;
            rx_data <= rx_shift[8:1];
            rx_rdy  <= 1'b1;
          end else begin
            rx_bits <= rx_bits + 4'd1;
          end
        end else begin
          rx_baud <= rx_baud - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/remote_comm.sv
// Remote-control transmitter: sends a 16-bit command as two UART bytes
// (high byte first) and presents the robot's single-byte response.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   RX         serial data from the robot
//   TX         serial data to the robot
//   cmd        command word, sampled when snd_cmd is accepted
//   snd_cmd    one-cycle send request (ignored while a command is in flight)
//   cmd_snt    set once both bytes have gone out, cleared by reset/new send
//   resp_rdy   high while resp holds an unacknowledged received byte
//   resp       last received byte
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  tx_state_t  state;
  logic [7:0] low_byte;
  logic       trmt;
  logic       tx_done;
  logic [7:0] tx_data;

  // High byte goes straight from cmd; the low byte comes from the holding
  // register so a changing cmd cannot disturb the command in flight.
  always_comb begin
    trmt    = 1'b0;
    tx_data = cmd[15:8];
    case (state)
      IDLE: trmt = snd_cmd;
      HIGH: begin
        trmt    = tx_done;
        tx_data = low_byte;
      end
      LOW:     tx_data = low_byte;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      low_byte <= '0;
      cmd_snt  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (snd_cmd) begin
          low_byte <= cmd[7:0];
          cmd_snt  <= 1'b0;
          state    <= HIGH;
        end
        HIGH: if (tx_done) state <= LOW;
        LOW: if (tx_done) begin
          cmd_snt <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  remote_comm_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst        (rst),
    .RX         (RX),
    .TX         (TX),
    .trmt       (trmt),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .rx_rdy     (resp_rdy),
    .rx_data    (resp),
    .clr_rx_rdy (snd_cmd)
  );

endmodule

// File: tb/tb_remote_comm.sv
module tb_remote_comm;
  import remote_comm_pkg::*;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RX = 1'b1;
  logic [15:0] cmd = '0;
  logic        snd_cmd = 1'b0;
  logic        TX, cmd_snt, resp_rdy;
  logic [7:0]  resp;

  logic [15:0] cmd2 = '0;
  logic        snd_cmd2 = 1'b0;
  logic        TX2, cmd_snt2, resp_rdy2;
  logic [7:0]  resp2;

  int total = 0;
  int bad = 0;
  logic [7:0] last_resp = '0;

  always #5 clk = ~clk;

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .snd_cmd(snd_cmd),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp)
  );

  // second instance listens to the first one's TX
  remote_comm #(.BAUD_DIV(BD)) peer (
    .clk(clk), .rst(rst), .RX(TX), .TX(TX2), .cmd(cmd2), .snd_cmd(snd_cmd2),
    .cmd_snt(cmd_snt2), .resp_rdy(resp_rdy2), .resp(resp2)
  );

  // Line level of bit i (0..9) of an 8N1 frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  // Sends v and checks the line at the middle of every bit. Frame 0 starts on
  // the edge that accepts snd_cmd, frame 1 one clock after frame 0's stop bit.
  task automatic check_tx(input logic [15:0] v, input int stop_at,
                          input bit interfere, input logic [15:0] other);
    int rise = -1;
    bit dropped = 0;
    int fs;
    logic [7:0] byt;
    logic want;
    @(negedge clk);
    cmd = v; snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0; cmd = 16'($urandom);
    total++;
    if (resp_rdy !== 1'b0) begin bad++; $display("FAIL snd_clears_rdy resp_rdy=%b want=0", resp_rdy); end
    total++;
    if (cmd_snt !== 1'b0) begin bad++; $display("FAIL snd_clears_snt cmd_snt=%b want=0", cmd_snt); end
    for (int c = 0; c <= 20*BD + 8; c++) begin
      if (interfere && c == 3*BD) begin cmd = other; snd_cmd = 1'b1; end
      if (interfere && c == 3*BD + 1) snd_cmd = 1'b0;
      for (int f = 0; f < 2; f++)
        for (int i = 0; i < 10; i++) begin
          fs = f * (10*BD + 1);
          if (c == fs + i*BD + BD/2) begin
            byt = (f == 0) ? v[15:8] : v[7:0];
            want = frame_bit(byt, i);
            total++;
            if (TX !== want) begin
              bad++;
              $display("FAIL tx_bit cmd=%h frame=%0d bit=%0d TX=%b want=%b", v, f, i, TX, want);
            end
          end
        end
      if (c == stop_at) return;
      if (cmd_snt === 1'b1 && rise < 0) rise = c;
      else if (rise >= 0 && cmd_snt !== 1'b1) dropped = 1;
      @(negedge clk);
    end
    total++;
    if (rise < 20*BD + 1 || rise > 20*BD + 3) begin
      bad++; $display("FAIL cmd_snt_time cmd=%h rise=%0d want=%0d..%0d", v, rise, 20*BD+1, 20*BD+3);
    end
    total++;
    if (dropped) begin bad++; $display("FAIL cmd_snt_held cmd=%h dropped=1 want=0", v); end
    total++;
    if (TX !== 1'b1) begin bad++; $display("FAIL tx_idle_after cmd=%h TX=%b want=1", v, TX); end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    for (int i = 0; i < 10; i++) begin
      if (i == 0) RX = 1'b0;
      else if (i == 9) RX = stop;
      else RX = b[i-1];
      repeat (BD) @(negedge clk);
    end
    RX = 1'b1;
  endtask

  // Drives one frame; checks resp_rdy drops at the start edge with resp held,
  // then rises about 9.5 bit times later with the new byte.
  task automatic rx_frame_check(input logic [7:0] b, input logic stop);
    int t = 0;
    fork
      drive_rx(b, stop);
      begin
        repeat (4) @(negedge clk);
        t = 4;
        total++;
        if (resp_rdy !== 1'b0) begin bad++; $display("FAIL rdy_clr_at_start resp_rdy=%b want=0", resp_rdy); end
        total++;
        if (resp !== last_resp) begin bad++; $display("FAIL resp_hold resp=%h want=%h", resp, last_resp); end
        while (resp_rdy !== 1'b1 && t < 400) begin @(negedge clk); t++; end
        total++;
        if (t < 9*BD + 4 || t > 10*BD + 2) begin
          bad++; $display("FAIL rx_rdy_time t=%0d want=%0d..%0d", t, 9*BD+4, 10*BD+2);
        end
        total++;
        if (resp !== b) begin bad++; $display("FAIL rx_data resp=%h want=%h stop=%b", resp, b, stop); end
      end
    join
    last_resp = b;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (TX !== 1'b1) begin bad++; $display("FAIL reset_tx TX=%b want=1", TX); end
    total++; if (cmd_snt !== 1'b0) begin bad++; $display("FAIL reset_snt cmd_snt=%b want=0", cmd_snt); end
    total++; if (resp_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy resp_rdy=%b want=0", resp_rdy); end
    total++; if (resp !== 8'h00) begin bad++; $display("FAIL reset_resp resp=%h want=00", resp); end
    rst = 1'b0;
    last_resp = '0;
    repeat (3) @(negedge clk);
    total++; if (TX !== 1'b1) begin bad++; $display("FAIL idle_tx TX=%b want=1", TX); end
  endtask

  task automatic test_tx;
    check_tx(CMD_MOVE, -1, 1'b0, '0);
    for (int k = 0; k < 3; k++) check_tx(16'($urandom), -1, 1'b0, '0);
  endtask

  task automatic test_rx;
    rx_frame_check(POS_ACK, 1'b1);
    rx_frame_check(8'($urandom), 1'b0);   // bad stop bit still delivers
    for (int k = 0; k < 2; k++) rx_frame_check(8'($urandom), 1'b1);
  endtask

  task automatic test_loopback;
    logic [7:0] got[$];
    logic prev;
    prev = resp_rdy2;
    fork
      check_tx(16'h1234, -1, 1'b0, '0);
      for (int t = 0; t < 20*BD + 12; t++) begin
        @(negedge clk);
        if (resp_rdy2 === 1'b1 && prev !== 1'b1) got.push_back(resp2);
        prev = resp_rdy2;
      end
    join
    total++;
    if (got.size() != 2) begin bad++; $display("FAIL loop_count got=%0d want=2", got.size()); end
    total++;
    if (got.size() < 1 || got[0] !== 8'h12) begin
      bad++; $display("FAIL loop_byte0 got=%h want=12", (got.size() > 0) ? got[0] : 8'hxx);
    end
    total++;
    if (got.size() < 2 || got[1] !== 8'h34) begin
      bad++; $display("FAIL loop_byte1 got=%h want=34", (got.size() > 1) ? got[1] : 8'hxx);
    end
  endtask

  task automatic test_ignore_busy;
    logic [15:0] v;
    v = 16'($urandom);
    check_tx(v, -1, 1'b1, ~v);
  endtask

  task automatic test_reset_mid;
    bit seen = 0;
    fork
      check_tx(CMD_MOVE, 10*BD + 1 + BD/2, 1'b0, '0);
      begin
        repeat (100) @(negedge clk);
        RX = 1'b0;                          // partial receive frame in flight
      end
    join
    #1 rst = 1'b1;
    #1;
    total++; if (TX !== 1'b1) begin bad++; $display("FAIL midrst_tx TX=%b want=1", TX); end
    total++; if (cmd_snt !== 1'b0) begin bad++; $display("FAIL midrst_snt cmd_snt=%b want=0", cmd_snt); end
    total++; if (resp_rdy !== 1'b0) begin bad++; $display("FAIL midrst_rdy resp_rdy=%b want=0", resp_rdy); end
    @(negedge clk);
    RX = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_resp = '0;
    for (int t = 0; t < 12*BD; t++) begin
      @(negedge clk);
      if (resp_rdy === 1'b1) seen = 1;
    end
    total++; if (seen) begin bad++; $display("FAIL midrst_no_byte seen=1 want=0"); end
    check_tx(CMD_CALIBRATE, -1, 1'b0, '0);
  endtask

  task automatic test_simultaneous;
    logic [15:0] v;
    logic [7:0]  b;
    for (int k = 0; k < 2; k++) begin
      v = (k == 0) ? CMD_MOVE : 16'($urandom);
      b = (k == 0) ? POS_ACK : 8'($urandom);
      fork
        check_tx(v, -1, 1'b0, '0);
        begin
          repeat (7) @(negedge clk);
          rx_frame_check(b, 1'b1);
        end
      join
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_loopback();
    test_ignore_busy();
    test_reset_mid();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time=%0t limit=1000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
